// File: rtl/run_length_ctrl_if.sv
// Request/grant and result bus of the run-length scanner.
// Requesters drive reqN/dataN (master side); the scanner returns grants and results (slave side).
interface run_length_ctrl_if;
  logic        req0;
  logic [31:0] data0;
  logic        req1;
  logic [31:0] data1;
  logic        gnt0;
  logic        gnt1;
  logic        busy;
  logic        valid;
  logic [5:0]  max_len;
  logic        done_id;
  logic [15:0] scan_count;

  // Handshake: reqN rises and stays high with dataN stable until the cycle gntN is
  // high; that cycle is the transfer. valid is a one-cycle result strobe with no back-pressure.
  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, busy, valid, max_len, done_id, scan_count
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, busy, valid, max_len, done_id, scan_count
  );
endinterface

// File: rtl/run_length_ctrl.sv
// Two-requester arbiter in front of a byte-serial scanner that finds the longest run of 1s
// in a 32-bit word: grant in IDLE, four SCAN cycles (MSB byte first), one DONE cycle.
module run_length_ctrl (
  input  logic                    clk,
  input  logic                    reset,
  run_length_ctrl_if.slave        bus,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_shift;
  logic [1:0]  r_byte_idx;
  logic [5:0]  r_cur;
  logic [5:0]  r_best;
  logic        r_owner;
  logic        r_last;
  logic [5:0]  r_max_len;
  logic        r_done_id;
  logic [15:0] r_scan_count;

  logic        w_gnt0;
  logic        w_gnt1;
  logic [7:0]  w_byte;
  logic [3:0]  w_lead;
  logic [3:0]  w_trail;
  logic [3:0]  w_inner;
  logic [5:0]  w_cur_lead;
  logic [5:0]  w_cur_nxt;
  logic [5:0]  w_best_nxt;
  logic [5:0]  w_final;

  function automatic logic [3:0] f_lead(input logic [7:0] b);
    logic [3:0] n;
    logic       stop;
    n    = 4'd0;
    stop = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!stop && b[i]) n = n + 4'd1;
      else               stop = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [3:0] f_trail(input logic [7:0] b);
    logic [3:0] n;
    logic       stop;
    n    = 4'd0;
    stop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!stop && b[i]) n = n + 4'd1;
      else               stop = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [3:0] f_inner(input logic [7:0] b);
    logic [3:0] run;
    logic [3:0] best;
    run  = 4'd0;
    best = 4'd0;
    for (int i = 0; i < 8; i++) begin
      run = b[i] ? run + 4'd1 : 4'd0;
      if (run > best) best = run;
    end
    return best;
  endfunction

  // Round-robin: on contention the requester not served last wins; reset is never a grant cycle.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE && !reset) begin
      if (bus.req0 && bus.req1) begin
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end else begin
        w_gnt0 = bus.req0;
        w_gnt1 = bus.req1;
      end
    end
  end

  // A full 0xFF byte extends the open run; any other byte closes it and starts a new one from its trail.
  always_comb begin
    w_byte     = r_shift[31:24];
    w_lead     = f_lead(w_byte);
    w_trail    = f_trail(w_byte);
    w_inner    = f_inner(w_byte);
    w_cur_lead = r_cur + {2'b00, w_lead};
    w_cur_nxt  = r_cur;
    w_best_nxt = r_best;
    if (w_byte == 8'hFF) begin
      w_cur_nxt = r_cur + 6'd8;
    end else begin
      w_best_nxt = r_best;
      if (w_cur_lead > w_best_nxt)         w_best_nxt = w_cur_lead;
      if ({2'b00, w_inner} > w_best_nxt)   w_best_nxt = {2'b00, w_inner};
      w_cur_nxt = {2'b00, w_trail};
    end
    w_final = (w_cur_nxt > w_best_nxt) ? w_cur_nxt : w_best_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt0 || w_gnt1) w_state_nxt = S_SCAN;
      S_SCAN:  if (r_byte_idx == 2'd3) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift      <= 32'd0;
      r_byte_idx   <= 2'd0;
      r_cur        <= 6'd0;
      r_best       <= 6'd0;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_max_len    <= 6'd0;
      r_done_id    <= 1'b0;
      r_scan_count <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_shift    <= w_gnt1 ? bus.data1 : bus.data0;
            r_owner    <= w_gnt1;
            r_last     <= w_gnt1;
            r_cur      <= 6'd0;
            r_best     <= 6'd0;
            r_byte_idx <= 2'd0;
          end
        end
        S_SCAN: begin
          r_shift    <= {r_shift[23:0], 8'h00};
          r_cur      <= w_cur_nxt;
          r_best     <= w_best_nxt;
          r_byte_idx <= r_byte_idx + 2'd1;
          // Result registers load on entry to DONE so they are stable while valid is high.
          if (r_byte_idx == 2'd3) begin
            r_max_len <= w_final;
            r_done_id <= r_owner;
          end
        end
        S_DONE: begin
          r_scan_count <= r_scan_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0       = w_gnt0;
  assign bus.gnt1       = w_gnt1;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.valid      = (r_state == S_DONE) && !reset;
  assign bus.max_len    = r_max_len;
  assign bus.done_id    = r_done_id;
  assign bus.scan_count = r_scan_count;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_run_length_ctrl.sv
// Bench for run_length_ctrl: table of single scans, random words against a bit-serial model,
// round-robin contention and a reset abort, all scored through an expected-result queue.
module tb_run_length_ctrl;
  localparam int W = 23;  // {grant cycle[15:0], id, max_len[5:0]}

  typedef struct {
    logic        sel;
    logic [31:0] data;
    logic [5:0]  exp_len;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [1:0]  dbg_state;
  int          cyc;
  int          checks;
  int          errors;
  logic [15:0] exp_count;
  logic [W-1:0] exp_q[$];

  run_length_ctrl_if bus ();

  run_length_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] ref_len(input logic [31:0] d);
    logic [5:0] run;
    logic [5:0] best;
    run  = 6'd0;
    best = 6'd0;
    for (int i = 0; i < 32; i++) begin
      run = d[i] ? run + 6'd1 : 6'd0;
      if (run > best) best = run;
    end
    return best;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [15:0]  lat;
    if (!reset && bus.valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e   = exp_q.pop_front();
        lat = cyc[15:0] - e[22:7];
        check("done_id", {31'd0, bus.done_id}, {31'd0, e[6]});
        check("max_len", {26'd0, bus.max_len}, {26'd0, e[5:0]});
        check("valid_latency", {16'd0, lat}, 32'd5);
        check("scan_count_at_valid", {16'd0, bus.scan_count}, {16'd0, exp_count});
        exp_count = exp_count + 16'd1;
      end
    end
    if (bus.gnt0 && bus.gnt1) check("dual_grant", 32'd1, 32'd0);
  end

  // driver tasks
  task automatic do_scan(input logic sel, input logic [31:0] d, input logic [5:0] exp_len);
    int t;
    @(negedge clk);
    if (sel) begin bus.req1 = 1'b1; bus.data1 = d; end
    else     begin bus.req0 = 1'b1; bus.data0 = d; end
    #1;
    t = 0;
    while (!(sel ? bus.gnt1 : bus.gnt0) && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 20) check("grant_timeout", 32'd1, 32'd0);
    else exp_q.push_back({cyc[15:0], sel, exp_len});
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk); #1;
    while ((exp_q.size() != 0 || bus.busy) && t < 60) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 60) begin
      check("drain_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
    check("scan_count_idle", {16'd0, bus.scan_count}, {16'd0, exp_count});
  endtask

  initial begin
    vec_t vecs[8];
    int   t;
    int   prev;
    logic [31:0] rnd;

    vecs[0] = '{1'b0, 32'h00000000, 6'd0};
    vecs[1] = '{1'b1, 32'hFFFFFFFF, 6'd32};
    vecs[2] = '{1'b0, 32'h00FFFF00, 6'd16};
    vecs[3] = '{1'b0, 32'h0F0FF0F0, 6'd8};
    vecs[4] = '{1'b0, 32'h80000001, 6'd1};
    vecs[5] = '{1'b0, 32'h7FFFFFFE, 6'd30};
    vecs[6] = '{1'b1, 32'h000000FF, 6'd8};
    vecs[7] = '{1'b1, 32'hAAAAAAAA, 6'd1};

    checks    = 0;
    errors    = 0;
    exp_count = 16'd0;
    reset     = 1'b1;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = 32'd0;
    bus.data1 = 32'd0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt0", {31'd0, bus.gnt0}, 32'd0);
    check("rst_gnt1", {31'd0, bus.gnt1}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_max_len", {26'd0, bus.max_len}, 32'd0);
    check("rst_done_id", {31'd0, bus.done_id}, 32'd0);
    check("rst_scan_count", {16'd0, bus.scan_count}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_scan(vecs[i].sel, vecs[i].data, vecs[i].exp_len);
      wait_idle();
    end

    for (int i = 0; i < 12; i++) begin
      rnd = $urandom;
      if (i % 3 == 0) rnd = rnd | (32'hFFFF << $urandom_range(0, 16));
      do_scan(1'(i % 2), rnd, ref_len(rnd));
    end
    wait_idle();

    // both requesters held from reset release: grants alternate 0,1,0,1 six cycles apart
    @(negedge clk);
    reset     = 1'b1;
    bus.req0  = 1'b1;
    bus.data0 = 32'h00FFFF00;
    bus.req1  = 1'b1;
    bus.data1 = 32'h80000001;
    #1;
    check("gnt_in_reset", {31'd0, bus.gnt0 | bus.gnt1}, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    exp_count = 16'd0;
    #1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!(bus.gnt0 || bus.gnt1) && t < 20) begin
        @(negedge clk); #1; t++;
      end
      if (t >= 20) begin
        check("rr_grant_timeout", 32'd1, 32'd0);
        break;
      end
      check("rr_grant_id", {31'd0, bus.gnt1}, 32'(k % 2));
      if (k > 0) check("rr_spacing", 32'(cyc - prev), 32'd6);
      prev = cyc;
      exp_q.push_back({cyc[15:0], bus.gnt1, bus.gnt1 ? 6'd1 : 6'd16});
      @(posedge clk); #1;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_idle();

    // reset at T+2 aborts the scan; the pending req0 is granted right after release
    @(negedge clk);
    bus.req0  = 1'b1;
    bus.data0 = 32'hFFFFFFFF;
    #1;
    check("abort_gnt", {31'd0, bus.gnt0}, 32'd1);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b1;
    bus.req0  = 1'b1;
    bus.data0 = 32'h0000000F;
    #1;
    check("abort_gnt_in_reset", {31'd0, bus.gnt0}, 32'd0);
    @(negedge clk); #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_valid", {31'd0, bus.valid}, 32'd0);
    check("abort_max_len", {26'd0, bus.max_len}, 32'd0);
    check("abort_scan_count", {16'd0, bus.scan_count}, 32'd0);
    reset     = 1'b0;
    exp_count = 16'd0;
    #1;
    check("post_reset_gnt0", {31'd0, bus.gnt0}, 32'd1);
    exp_q.push_back({cyc[15:0], 1'b0, 6'd4});
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    wait_idle();
    check("final_scan_count", {16'd0, bus.scan_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/run_length_ctrl.md
RUN_LENGTH_CTRL -- requirements
Module: run_length_ctrl

Interface
REQ-001 SHALL have clk, input, 1, the single clock; every register updates on its rising edge.
REQ-002 SHALL have reset, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have req0, input, 1, requester 0 asks for a scan; held high until gnt0.
REQ-004 SHALL have data0, input, 32, requester 0 operand; stable while req0 is high.
REQ-005 SHALL have req1, input, 1, requester 1 asks for a scan; held high until gnt1.
REQ-006 SHALL have data1, input, 32, requester 1 operand; stable while req1 is high.
REQ-007 SHALL have gnt0 and gnt1, output, 1 each, one-cycle grant pulses; the operand is captured in that cycle.
REQ-008 SHALL have busy, output, 1, high in SCAN and DONE.
REQ-009 SHALL have valid, output, 1, one-cycle pulse when result is available.
REQ-010 SHALL have max_len, output, 6, longest run of consecutive 1s in the scanned word, 0..32.
REQ-011 SHALL have done_id, output, 1, index of the requester that owns max_len.
REQ-012 SHALL have scan_count, output, 16, number of completed scans; wraps 0xFFFF->0x0000.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-014 IDLE: with no request, SHALL stay in IDLE with gnt0=gnt1=0.
REQ-015 IDLE with exactly one reqN high: SHALL assert gntN and latch dataN, set owner=N, go to SCAN; this cycle is T.
REQ-016 IDLE with both requests high: SHALL grant the requester other than last_served (round-robin).
REQ-017 last_served SHALL update to the granted index on every grant.
REQ-018 At most one gnt SHALL be high in any cycle; no grant SHALL occur outside IDLE.
REQ-019 SCAN SHALL last exactly 4 cycles (T+1..T+4) and process one byte per cycle, MSB byte first (bits 31:24 first).
REQ-020 For each byte, SHALL compute lead (count of leading 1s from the MSB), trail (count of trailing 1s from the LSB), and inner (longest internal run).
REQ-021 For a byte of 0xFF: cur SHALL become cur+8, and best SHALL be unchanged.
REQ-022 For any other byte: best SHALL become max(best, cur+lead, inner), and cur SHALL become trail.
REQ-023 cur and best SHALL be 6-bit and cleared at grant; no overflow is possible (max 32).
REQ-024 After the 4th byte, SHALL go to DONE with best'=max(best,cur).
REQ-025 DONE (cycle T+5): SHALL register max_len=best', done_id=owner, and pulse valid.
REQ-026 DONE (cycle T+5): SHALL increment scan_count and return to IDLE.
REQ-027 SHALL accept a new grant at T+6 at the earliest; the throughput is one scan per 6 cycles.
REQ-028 max_len and done_id SHALL hold their last value until the next valid.
REQ-029 A request raised during SCAN/DONE SHALL wait, and SHALL NOT be lost while held.

Reset
REQ-030 Reset SHALL force IDLE and clear gnt0, gnt1, busy, valid, max_len, done_id, scan_count, cur, best and the shift register.
REQ-031 Reset SHALL set last_served=1 so that req0 wins the first contention.
REQ-032 Reset asserted mid-SCAN or in DONE SHALL abort the scan, with no valid pulse and no scan_count increment.
REQ-033 Reset SHALL have priority over a simultaneous request; no grant is issued in a reset cycle.

Verification
REQ-034 req0, data0=0x00000000 -> gnt0 at T, valid at T+5, max_len=0, done_id=0, scan_count=1.
REQ-035 req1, data1=0xFFFFFFFF -> max_len=32, done_id=1.
REQ-036 Cross-byte and edge patterns:
- data0=0x00FFFF00 -> 16
- data0=0x0F0FF0F0 -> 8
- data0=0x80000001 -> 1
- data0=0x7FFFFFFE -> 30
REQ-037 req0 and req1 held high continuously from reset release -> grants alternate gnt0, gnt1, gnt0, ...; grants spaced 6 cycles apart; done_id alternates 0,1,0.
REQ-038 Reset pulsed at T+2 of a scan -> no valid; max_len=0; scan_count=0; a pending req0 is granted in the first cycle after reset deasserts.
REQ-039 65536 back-to-back scans -> scan_count wraps to 0x0000.
